// File: rtl/clz_pipe_norm.sv
// Two-stage pipelined leading-zero / leading-one / trailing-zero counter with a
// normalising barrel shift. S1 captures the word plus per-byte leading-zero
// counts of the scan word; S2 merges those counts and shifts the original word.
module clz_pipe_norm #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [1:0]       out_mode
);

  localparam int NCH = (WIDTH + 7) / 8;

  typedef enum logic [1:0] {
    MODE_CLZ = 2'b00,
    MODE_CLO = 2'b01,
    MODE_CTZ = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  logic                  s1_valid_q;
  logic [WIDTH-1:0]      s1_data_q;
  mode_e                 s1_mode_q;
  logic [NCH-1:0][3:0]   s1_cnt_q, s1_cnt_d;

  logic                  s2_valid_q;
  logic [CW-1:0]         s2_count_q, s2_count_d;
  logic                  s2_zero_q, s2_zero_d;
  logic [WIDTH-1:0]      s2_norm_q, s2_norm_d;
  mode_e                 s2_mode_q;

  logic                  s1_load, s2_load;
  logic [WIDTH-1:0]      scan;
  logic                  chunk_stop;
  int unsigned           chunk_lz;
  int unsigned           bit_idx;
  int unsigned           total;
  logic                  found;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Map every mode onto a leading-zero scan: invert for CLO, bit-reverse for CTZ.
  always_comb begin
    scan = in_data;
    case (mode_e'(in_mode))
      MODE_CLO: scan = ~in_data;
      MODE_CTZ: begin
        for (int unsigned i = 0; i < WIDTH; i++) scan[i] = in_data[WIDTH-1-i];
      end
      default: scan = in_data;
    endcase
  end

  // Leading-zero count of each 8-bit chunk from the MSB end; the last chunk may be partial.
  always_comb begin
    s1_cnt_d   = '0;
    chunk_stop = 1'b0;
    chunk_lz   = 0;
    bit_idx    = 0;
    for (int unsigned c = 0; c < NCH; c++) begin
      chunk_stop = 1'b0;
      chunk_lz   = 0;
      for (int unsigned b = 0; b < 8; b++) begin
        if (8 * c + b < WIDTH) begin
          bit_idx = WIDTH - 1 - 8 * c - b;
          if (!chunk_stop) begin
            if (scan[bit_idx]) chunk_stop = 1'b1;
            else               chunk_lz   = chunk_lz + 1;
          end
        end
      end
      s1_cnt_d[c] = 4'(chunk_lz);
    end
  end

  // Stage 1 register: raw word, mode and chunk counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_CLZ;
      s1_cnt_q   <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_data;
        s1_mode_q <= mode_e'(in_mode);
        s1_cnt_q  <= s1_cnt_d;
      end
    end
  end

  // Merge chunk counts: accumulate full chunks until the first one holding a set bit,
  // then shift the original word; CLO shifts the complement so vacated bits fill with 1.
  always_comb begin
    total = 0;
    found = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (!found) begin
        total = total + int'(s1_cnt_q[c]);
        if (int'(s1_cnt_q[c]) != ((WIDTH - 8 * c >= 8) ? 8 : WIDTH - 8 * c)) found = 1'b1;
      end
    end
    s2_count_d = CW'(total);
    s2_zero_d  = !found;
    case (s1_mode_q)
      MODE_CLO: s2_norm_d = ~((~s1_data_q) << s2_count_d);
      MODE_CTZ: s2_norm_d = s1_data_q >> s2_count_d;
      default:  s2_norm_d = s1_data_q << s2_count_d;
    endcase
  end

  // Stage 2 register: these are the block outputs and hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_count_q <= '0;
      s2_zero_q  <= 1'b0;
      s2_norm_q  <= '0;
      s2_mode_q  <= MODE_CLZ;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_count_q <= s2_count_d;
        s2_zero_q  <= s2_zero_d;
        s2_norm_q  <= s2_norm_d;
        s2_mode_q  <= s1_mode_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_count = s2_count_q;
  assign out_zero  = s2_zero_q;
  assign out_norm  = s2_norm_q;
  assign out_mode  = s2_mode_q;

endmodule

// File: tb/tb_clz_pipe_norm.sv
// Bench for clz_pipe_norm: table of hand-computed vectors streamed through a
// scoreboard, plus directed sequences for latency, stalls, reset and WIDTH=20.
module tb_clz_pipe_norm;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_data, out_norm;
  logic [1:0]  in_mode, out_mode;
  logic [5:0]  out_count;

  logic        in_valid20, in_ready20, out_valid20, out_ready20, out_zero20;
  logic [19:0] in_data20, out_norm20;
  logic [1:0]  in_mode20, out_mode20;
  logic [4:0]  out_count20;

  clz_pipe_norm #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_zero(out_zero), .out_norm(out_norm), .out_mode(out_mode)
  );

  clz_pipe_norm #(.WIDTH(20)) dut20 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid20), .in_ready(in_ready20), .in_data(in_data20), .in_mode(in_mode20),
    .out_valid(out_valid20), .out_ready(out_ready20), .out_count(out_count20),
    .out_zero(out_zero20), .out_norm(out_norm20), .out_mode(out_mode20)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    logic [5:0]  count;
    logic        zero;
    logic [31:0] norm;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t cur;
  int unsigned passed = 0, total = 0, pushed = 0, popped = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(logic [31:0] d, logic [1:0] m, logic [5:0] c, logic z, logic [31:0] n);
    vec_t v;
    v.data = d; v.mode = m; v.count = c; v.zero = z; v.norm = n;
    return v;
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge, so a
  // handshake seen here is the one that completes on the next rising edge.
  always @(negedge clk) begin
    vec_t e;
    if (rst) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", out_valid, 1'b0);
        else begin
          e = sb.pop_front();
          popped++;
          chk("count", out_count, e.count);
          chk("zero",  out_zero,  e.zero);
          chk("norm",  out_norm,  e.norm);
          chk("mode",  out_mode,  e.mode);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur);
        pushed++;
      end
    end
  end

  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = v.data; in_mode = v.mode; cur = v;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] base, w;
    logic [5:0]  s_cnt;
    logic [31:0] s_norm;
    logic        s_zero;
    logic [1:0]  s_mode;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    in_valid20 = 1'b0; in_data20 = '0; in_mode20 = '0; out_ready20 = 1'b1;
    cur = mk(0, 0, 0, 0, 0);
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_zero",  out_zero,  1'b0);
    chk("rst_out_norm",  out_norm,  0);
    chk("rst_out_mode",  out_mode,  0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid20", out_valid20, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // T1 sweep: MSB-set word shifted right by i gives count i and norm with the low i bits cleared
    base = 32'hB3C5_1A27;
    for (int i = 0; i <= 32; i++) begin
      w = base >> i;
      vecs.push_back(mk(w, 2'b00, 6'(i), i == 32, (i == 32) ? 32'h0 : ((base >> i) << i)));
    end
    // T2 modes and boundaries
    vecs.push_back(mk(32'h0000_0001, 2'b00, 31, 0, 32'h8000_0000));
    vecs.push_back(mk(32'hFFFF_0000, 2'b01, 16, 0, 32'h0000_FFFF));
    vecs.push_back(mk(32'h0000_0100, 2'b10,  8, 0, 32'h0000_0001));
    vecs.push_back(mk(32'hFFFF_FFFF, 2'b01, 32, 1, 32'hFFFF_FFFF));
    vecs.push_back(mk(32'h0000_0000, 2'b10, 32, 1, 32'h0000_0000));
    vecs.push_back(mk(32'h0000_00F0, 2'b11, 24, 0, 32'hF000_0000));
    vecs.push_back(mk(32'h0000_0000, 2'b11, 32, 1, 32'h0000_0000));
    vecs.push_back(mk(32'h8000_0000, 2'b01,  1, 0, 32'h0000_0001));
    vecs.push_back(mk(32'h8000_0000, 2'b10, 31, 0, 32'h0000_0001));
    vecs.push_back(mk(32'hFFFF_FFFE, 2'b01, 31, 0, 32'h7FFF_FFFF));
    vecs.push_back(mk(32'hFFFF_FFFF, 2'b10,  0, 0, 32'hFFFF_FFFF));
    vecs.push_back(mk(32'h0040_0000, 2'b00,  9, 0, 32'h8000_0000));
    vecs.push_back(mk(32'h0000_0080, 2'b00, 24, 0, 32'h8000_0000));
    vecs.push_back(mk(32'h0001_0000, 2'b10, 16, 0, 32'h0000_0001));

    foreach (vecs[i]) send(vecs[i]);
    in_valid = 1'b0;
    drain();

    // T3 latency and throughput: 10 back-to-back words, no bubbles
    for (int k = 0; k < 10; k++) begin
      w = 32'h1 << (3 * k);
      in_valid = 1'b1; in_data = w; in_mode = 2'b00;
      cur = mk(w, 2'b00, 6'(31 - 3 * k), 0, 32'h8000_0000);
      @(negedge clk);
      chk("t3_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      if (k == 0) chk("t3_latency_not_1", out_valid, 1'b0);
      else        chk("t3_no_bubble", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t3_tenth_result", out_valid, 1'b1);
    @(posedge clk); #1;
    chk("t3_done", out_valid, 1'b0);
    drain();

    // T4 backpressure: two words fill the pipe, third waits; outputs hold
    out_ready = 1'b0;
    send(mk(32'h0001_0000, 2'b00, 15, 0, 32'h8000_0000));
    send(mk(32'hF0F0_0000, 2'b01,  4, 0, 32'h0F00_000F));
    in_valid = 1'b1; in_data = 32'h0000_0A00; in_mode = 2'b10;
    cur = mk(32'h0000_0A00, 2'b10, 9, 0, 32'h0000_0005);
    @(negedge clk);
    chk("t4_in_ready_low", in_ready, 1'b0);
    chk("t4_out_valid", out_valid, 1'b1);
    chk("t4_head_count", out_count, 15);
    s_cnt = out_count; s_norm = out_norm; s_zero = out_zero; s_mode = out_mode;
    repeat (3) @(negedge clk);
    chk("t4_hold_count", out_count, s_cnt);
    chk("t4_hold_norm",  out_norm,  s_norm);
    chk("t4_hold_zero",  out_zero,  s_zero);
    chk("t4_hold_mode",  out_mode,  s_mode);
    chk("t4_hold_valid", out_valid, 1'b1);
    chk("t4_still_stalled", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(cur);
    in_valid = 1'b0;
    drain();
    chk("t4_no_loss_dup", popped, pushed);

    // T5 reset with two words in flight
    send(mk(32'h0000_0010, 2'b00, 27, 0, 32'h8000_0000));
    send(mk(32'h0000_0020, 2'b00, 26, 0, 32'h8000_0000));
    in_valid = 1'b0;
    chk("t5_busy_before_rst", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1 chk("t5_async_clear", out_valid, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    chk("t5_in_ready", in_ready, 1'b1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t5_no_stale", out_valid, 1'b0);
    end

    // T6 WIDTH=20 instance
    @(posedge clk); #1;
    in_valid20 = 1'b1; in_data20 = 20'h0_0000; in_mode20 = 2'b00;
    @(posedge clk); #1;
    in_data20 = 20'h0_0800; in_mode20 = 2'b00;
    @(posedge clk); #1;
    in_data20 = 20'hF_FFFF; in_mode20 = 2'b01;
    chk("w20_a_valid", out_valid20, 1'b1);
    chk("w20_a_count", out_count20, 20);
    chk("w20_a_zero",  out_zero20,  1'b1);
    chk("w20_a_norm",  out_norm20,  20'h0_0000);
    @(posedge clk); #1;
    in_valid20 = 1'b0;
    chk("w20_b_count", out_count20, 8);
    chk("w20_b_zero",  out_zero20,  1'b0);
    chk("w20_b_norm",  out_norm20,  20'h8_0000);
    @(posedge clk); #1;
    chk("w20_c_count", out_count20, 20);
    chk("w20_c_zero",  out_zero20,  1'b1);
    chk("w20_c_norm",  out_norm20,  20'hF_FFFF);
    chk("w20_c_mode",  out_mode20,  2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
